// File: rtl/sqrt_req_queue.sv
// sqrt_req_queue: operand issue queue in front of the CORDIC square-root core.
// Buffers signed operands in a small circular FIFO, drops negative operands
// (flagging them on err_neg), and issues one operand at a time to the core,
// waiting for its completion pulse before issuing the next.
module sqrt_req_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_val,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_rdy,
    input  logic                       core_ready,
    input  logic                       core_done,
    output logic                       core_val,
    output logic [WIDTH-1:0]           core_A,
    output logic                       err_neg,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           state_q, state_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             core_val_q, core_val_d;
    logic [WIDTH-1:0] core_A_q, core_A_d;
    logic             err_neg_q, err_neg_d;

    logic             accept;
    logic             is_neg;
    logic             push;
    logic             pop;

    // Handshake decode: acceptance, negative screen, and the issue (pop) condition.
    always_comb begin
        in_rdy = (count_q != CW'(DEPTH));
        accept = in_val && in_rdy;
        is_neg = in_data[WIDTH-1];
        push   = accept && !is_neg;
        pop    = (state_q == S_IDLE) && (count_q != '0) && core_ready;
    end

    // Issue FSM next-state: one operand in flight, released by the core's done pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO storage, pointers and occupancy; pop reads the pre-edge head, so a
    // push into an empty FIFO cannot be issued on the same edge.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Core-side outputs: one-cycle valid pulse, operand held until the next issue,
    // and a one-cycle error flag for each discarded negative operand.
    always_comb begin
        core_val_d = pop;
        core_A_d   = core_A_q;
        err_neg_d  = accept && is_neg;
        if (pop) begin
            core_A_d = mem_q[rd_ptr_q];
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            core_val_q <= 1'b0;
            core_A_q   <= '0;
            err_neg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            core_val_q <= core_val_d;
            core_A_q   <= core_A_d;
            err_neg_q  <= err_neg_d;
        end
    end

    // FIFO data array; contents are only meaningful under the pointers, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign core_val = core_val_q;
    assign core_A   = core_A_q;
    assign err_neg  = err_neg_q;
    assign busy     = (state_q == S_WAIT);
    assign count    = count_q;

endmodule

// File: tb/tb_sqrt_req_queue.sv
// Testbench for sqrt_req_queue: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based reference.
module tb_sqrt_req_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        in_val;
    logic [15:0] in_data;
    logic        in_rdy;
    logic        core_ready;
    logic        core_done;
    logic        core_val;
    logic [15:0] core_A;
    logic        err_neg;
    logic        busy;
    logic [2:0]  count;

    sqrt_req_queue #(.WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_val     (in_val),
        .in_data    (in_data),
        .in_rdy     (in_rdy),
        .core_ready (core_ready),
        .core_done  (core_done),
        .core_val   (core_val),
        .core_A     (core_A),
        .err_neg    (err_neg),
        .busy       (busy),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: queue contents, in-flight flag, registered outputs.
    logic [15:0] m_q [$];
    bit          m_inflight = 0;
    bit          m_val = 0;
    logic [15:0] m_A = '0;
    bit          m_err = 0;
    bit          m_acc = 0;

    logic [15:0] issued [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare outputs.
    task automatic step(input bit r, input bit iv, input logic [15:0] d,
                        input bit cr, input bit cd);
        bit pop;
        bit acc;
        reset = r; in_val = iv; in_data = d; core_ready = cr; core_done = cd;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_inflight = 0; m_val = 0; m_A = '0; m_err = 0; m_acc = 0;
        end else begin
            pop = !m_inflight && (m_q.size() > 0) && cr;
            acc = iv && (m_q.size() < DEPTH);
            m_val = pop;
            if (pop) begin
                m_A = m_q.pop_front();
                m_inflight = 1;
            end else if (m_inflight && cd) begin
                m_inflight = 0;
            end
            if (acc && !d[15]) m_q.push_back(d);
            m_err = acc && d[15];
            m_acc = acc;
        end
        #1;
        chk("mdl_core_val", core_val, m_val);
        chk("mdl_core_A",   core_A,   m_A);
        chk("mdl_err_neg",  err_neg,  m_err);
        chk("mdl_busy",     busy,     m_inflight);
        chk("mdl_count",    count,    m_q.size());
        chk("mdl_in_rdy",   in_rdy,   m_q.size() != DEPTH);
    endtask

    // Emulate the core (done one cycle after each valid) until the queue drains,
    // optionally keeping one pending operand offered until it is accepted.
    task automatic drain(input bit have_pend, input logic [15:0] pend,
                         input bit cd0, input int budget);
        bit cd;
        int n;
        bit pending;
        cd = cd0; n = 0; pending = have_pend;
        while ((pending || m_q.size() != 0 || m_inflight) && n < budget) begin
            step(0, pending, pend, 1, cd);
            if (m_acc) pending = 0;
            if (core_val === 1'b1) issued.push_back(core_A);
            cd = core_val;
            n++;
        end
        chk("drain_timeout", n < budget, 1);
    endtask

    typedef struct {
        bit          r;
        bit          iv;
        logic [15:0] d;
        bit          cr;
        bit          cd;
        bit          e_val;
        logic [15:0] e_A;
        bit          e_err;
        bit          e_busy;
        int          e_cnt;
        bit          e_rdy;
    } vec_t;

    vec_t vt [18];

    initial begin
        logic [15:0] exp_fill [5];
        logic [15:0] exp_sim  [3];

        reset = 1'b1; in_val = 1'b0; in_data = '0; core_ready = 1'b0; core_done = 1'b0;

        // Single operand, negative screen, stray done, negative on a pop edge.
        vt[0]  = '{1, 1, 16'h1234, 1, 0,  0, 16'h0000, 0, 0, 0, 1};
        vt[1]  = '{0, 1, 16'h1000, 1, 0,  0, 16'h0000, 0, 0, 1, 1};
        vt[2]  = '{0, 0, 16'h0000, 1, 0,  1, 16'h1000, 0, 1, 0, 1};
        vt[3]  = '{0, 0, 16'h0000, 1, 0,  0, 16'h1000, 0, 1, 0, 1};
        vt[4]  = '{0, 0, 16'h0000, 1, 1,  0, 16'h1000, 0, 0, 0, 1};
        vt[5]  = '{0, 0, 16'h0000, 1, 0,  0, 16'h1000, 0, 0, 0, 1};
        vt[6]  = '{0, 1, 16'h0800, 0, 0,  0, 16'h1000, 0, 0, 1, 1};
        vt[7]  = '{0, 1, 16'hF800, 0, 0,  0, 16'h1000, 1, 0, 1, 1};
        vt[8]  = '{0, 1, 16'h1000, 0, 0,  0, 16'h1000, 0, 0, 2, 1};
        vt[9]  = '{0, 0, 16'h0000, 1, 0,  1, 16'h0800, 0, 1, 1, 1};
        vt[10] = '{0, 0, 16'h0000, 1, 0,  0, 16'h0800, 0, 1, 1, 1};
        vt[11] = '{0, 0, 16'h0000, 0, 1,  0, 16'h0800, 0, 0, 1, 1};
        vt[12] = '{0, 0, 16'h0000, 1, 0,  1, 16'h1000, 0, 1, 0, 1};
        vt[13] = '{0, 0, 16'h0000, 0, 1,  0, 16'h1000, 0, 0, 0, 1};
        vt[14] = '{0, 0, 16'h0000, 0, 1,  0, 16'h1000, 0, 0, 0, 1};
        vt[15] = '{0, 1, 16'h0400, 0, 0,  0, 16'h1000, 0, 0, 1, 1};
        vt[16] = '{0, 1, 16'h8000, 1, 0,  1, 16'h0400, 1, 1, 0, 1};
        vt[17] = '{0, 0, 16'h0000, 0, 1,  0, 16'h0400, 0, 0, 0, 1};

        for (int i = 0; i < 18; i++) begin
            step(vt[i].r, vt[i].iv, vt[i].d, vt[i].cr, vt[i].cd);
            chk($sformatf("vec%0d_core_val", i), core_val, vt[i].e_val);
            chk($sformatf("vec%0d_core_A", i),   core_A,   vt[i].e_A);
            chk($sformatf("vec%0d_err_neg", i),  err_neg,  vt[i].e_err);
            chk($sformatf("vec%0d_busy", i),     busy,     vt[i].e_busy);
            chk($sformatf("vec%0d_count", i),    count,    vt[i].e_cnt);
            chk($sformatf("vec%0d_in_rdy", i),   in_rdy,   vt[i].e_rdy);
        end

        // Fill and stall: four accepted, fifth held until space frees up.
        step(1, 0, 16'h0, 0, 0);
        step(0, 1, 16'h0800, 0, 0);
        step(0, 1, 16'h1000, 0, 0);
        step(0, 1, 16'h1800, 0, 0);
        step(0, 1, 16'h2000, 0, 0);
        chk("fill_count4", count, 3'd4);
        chk("fill_rdy0", in_rdy, 1'b0);
        step(0, 1, 16'h2800, 0, 0);
        chk("fill_fifth_held", count, 3'd4);
        issued.delete();
        drain(1, 16'h2800, 0, 200);
        exp_fill[0] = 16'h0800; exp_fill[1] = 16'h1000; exp_fill[2] = 16'h1800;
        exp_fill[3] = 16'h2000; exp_fill[4] = 16'h2800;
        chk("fill_issue_cnt", issued.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < issued.size()) chk($sformatf("fill_issue%0d", i), issued[i], exp_fill[i]);

        // Simultaneous push and pop on the issue edge.
        step(1, 0, 16'h0, 0, 0);
        step(0, 1, 16'h1111, 0, 0);
        step(0, 1, 16'h2222, 0, 0);
        step(0, 1, 16'h3000, 1, 0);
        chk("sim_count2", count, 3'd2);
        chk("sim_val", core_val, 1'b1);
        chk("sim_old_head", core_A, 16'h1111);
        issued.delete();
        issued.push_back(core_A);
        drain(0, 16'h0, 1, 200);
        exp_sim[0] = 16'h1111; exp_sim[1] = 16'h2222; exp_sim[2] = 16'h3000;
        chk("sim_issue_cnt", issued.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < issued.size()) chk($sformatf("sim_issue%0d", i), issued[i], exp_sim[i]);

        // Reset mid-flight flushes everything; operands offered during reset are dropped.
        step(1, 0, 16'h0, 0, 0);
        step(0, 1, 16'h0100, 0, 0);
        step(0, 1, 16'h0200, 0, 0);
        step(0, 1, 16'h0300, 0, 0);
        step(0, 1, 16'h0400, 0, 0);
        step(0, 0, 16'h0000, 1, 0);
        chk("rst_pre_busy", busy, 1'b1);
        chk("rst_pre_count", count, 3'd3);
        step(1, 1, 16'h7777, 1, 0);
        chk("rst_count", count, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_val", core_val, 1'b0);
        chk("rst_A", core_A, 16'h0000);
        chk("rst_rdy", in_rdy, 1'b1);
        step(0, 0, 16'h0000, 1, 0);
        chk("rst_nothing_stored", count, 3'd0);
        chk("rst_no_issue", core_val, 1'b0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0), $urandom_range(1), 16'($urandom()),
                 $urandom_range(1), ($urandom_range(9) < 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sqrt_req_queue.md
# sqrt_req_queue

Operand issue queue sitting directly upstream of the CORDIC square-root core. It buffers a stream of signed 16-bit operands in a small FIFO and screens out negative values, which it drops and flags. It issues each remaining operand to the core with a one-cycle `operands_val` pulse, then holds off the next issue until the core reports completion with `sqrt_valid`. This decouples producers that burst operands from a core that accepts one operand at a time.

## Interface

Parameters:
- `WIDTH`, 16, operand width; must match the core's `A` port.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_val`  in  1  producer operand valid.
- `in_data`  in  WIDTH  signed operand, same fixed-point format as the core (0x0800 = 1.0).
- `in_rdy`  out  1  queue can accept an operand.
- `core_ready`  in  1  core `ready` (core idle).
- `core_done`  in  1  core `sqrt_valid` completion pulse.
- `core_val`  out  1  drives core `operands_val`; one-cycle pulse.
- `core_A`  out  WIDTH  drives core `A`; held stable from issue until the next issue.
- `err_neg`  out  1  one-cycle pulse: a negative operand was accepted and discarded.
- `busy`  out  1  an operand is in flight in the core (state WAIT).
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation

- **Accept:** an operand is accepted on a clock edge when `in_val && in_rdy`.
  - `in_rdy = (count != DEPTH)`; it is combinational from `count` only and never depends on `in_val`.
- **Negative screen:** an accepted operand with `in_data[WIDTH-1] == 1` is not written to the FIFO. `err_neg` is high for the following cycle.
  - Zero and all non-negative values are written normally.
- **FIFO storage:** circular buffer with read and write pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- **Issue FSM, 2 states:**
  - IDLE → WAIT when `count != 0 && core_ready`. On that edge: `core_val <= 1`, `core_A <= head`, the head is popped and `count` decrements.
  - WAIT: `core_val <= 0`, `busy = 1`. Go to IDLE on the edge where `core_done == 1`.
  - Any other condition: remain in the current state.
- **One operand in flight:** at most one operand is outstanding at any time. A new issue is never made from WAIT, even if `core_ready` reads 1.
- **Simultaneous push and pop in one edge:** both happen and `count` is unchanged.
  - A pop always takes the entry that was the head before the edge. A push into an empty FIFO is not issuable on the same edge.
  - A negative operand arriving on a pop edge counts as a pop only: `count` decrements by 1.
- **Full FIFO:** `in_rdy = 0`. Producer data is ignored; nothing is overwritten.
- **Unexpected `core_done` in IDLE:** ignored.

## Timing

- **Reset values:** `core_val=0`, `core_A=0`, `err_neg=0`, `busy=0`, `count=0`, pointers 0, state IDLE.
  - `in_rdy` reads 1 while in reset, but operands presented during reset are not accepted.
- **Reset mid-operation:** flushes the FIFO and forces IDLE in one edge. Any in-flight result is abandoned; the core shares the same reset.
- **Issue latency:** with the FIFO empty and the core idle, an operand accepted at edge E0 is issued at edge E1. `core_val` is high for the cycle after E1.
- **Back-to-back:** after `core_done` at edge Ed, the next issue can occur at Ed+1 if `core_ready` is high then. That gives a minimum of 1 idle cycle between `core_done` and the next `core_val`.
- **`err_neg` timing:** asserts exactly one cycle after the accepting edge. It never asserts on consecutive cycles unless consecutive negative operands are accepted.
- **`core_A` hold:** unchanged from the issue edge until the next issue edge.

## Test plan

- **Single operand:** push 0x1000 (2.0) into an idle system; core_ready=1.
  - Response: `core_val` pulses exactly 1 cycle, 1 edge after acceptance, with `core_A=0x1000`.
  - `busy=1` until `core_done`; then IDLE and `count=0`.
- **Fill and stall:** hold core_ready=0 and push 5 operands 0x0800, 0x1000, 0x1800, 0x2000, 0x2800 on consecutive cycles.
  - The first 4 are accepted; `in_rdy=0` once `count=4`, so the fifth is held.
  - Raise core_ready: issues go in order 0x0800, 0x1000, …, each waiting for `core_done`. The fifth operand is accepted as soon as `count=3`.
- **Negative screen:** push 0x0800, then 0xF800, then 0x1000.
  - `err_neg` pulses once, 1 cycle after 0xF800 is accepted.
  - Only 0x0800 and 0x1000 are issued; `count` never exceeds 2.
- **Simultaneous push and pop:** `count=2`; on the issue edge also push 0x3000.
  - `count` stays 2; the issued value is the old head.
  - 0x3000 is the last operand issued.
- **No issue in WAIT:** while `busy=1`, toggle core_ready high.
  - No `core_val` pulse occurs until a `core_done` is applied.
  - A stray `core_done` in IDLE has no effect.
- **Reset mid-flight:** with `count=3` and `busy=1`, assert reset for 1 cycle.
  - Next cycle: `count=0`, `busy=0`, `core_val=0`, `core_A=0`, `in_rdy=1`.
  - Operands pushed during reset are not stored.
